// File: rtl/ckrs_pkg.sv
// Clock/reset bundle shared by the GBT frame-clock-domain blocks.
package ckrs_pkg;
    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;
endpackage

// File: rtl/gbt_page_scheduler.sv
// Sequences register pages onto the serial TX word; manual or auto-scan page selection.
// Latency: request at t -> tx_load_o at t+3 when TX is idle.
// Backpressure: holds in WAIT_IDLE while tx_busy_i is high, re-snapshotting on newer requests.
module gbt_page_scheduler
    import ckrs_pkg::*;
#(
    parameter int          NUM_PAGES   = 24,
    parameter int          ACK_TIMEOUT = 1024,
    parameter logic [31:0] BAD_PAGE    = 32'hdeadbeef
) (
    input  ckrs_t                     ClkRs_ix,
    input  logic [31:0]               req_ib32,
    input  logic                      req_valid_i,
    input  logic [32*NUM_PAGES-1:0]   pages_ib32,
    input  logic                      tx_busy_i,
    output logic [31:0]               tx_data_ob32,
    output logic                      tx_load_o,
    output logic [7:0]                cur_page_ob8,
    output logic [31:0]               frames_ob32,
    output logic                      scanning_o,
    output logic                      timeout_o
);

    localparam int             CW       = $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0]  ACK_LAST = CW'(ACK_TIMEOUT - 2);
    localparam logic [7:0]     LAST_IDX = 8'(NUM_PAGES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        WAIT_IDLE,
        LOAD,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t          state;
    logic            pending;
    logic            scan_hold;
    logic [7:0]      man_idx;
    logic [7:0]      scan_idx;
    logic [CW-1:0]   ack_cnt;
    logic [7:0]      snap_idx;
    logic [31:0]     sel_word;
    logic            unused_req;

    assign unused_req = ^req_ib32[30:8];
    assign snap_idx   = scanning_o ? scan_idx : man_idx;

    // Full 8-bit compare: indices at or beyond NUM_PAGES fall through to BAD_PAGE.
    always_comb begin
        sel_word = BAD_PAGE;
        for (int k = 0; k < NUM_PAGES; k++) begin
            if (snap_idx == 8'(k)) begin
                sel_word = pages_ib32[32*k +: 32];
            end
        end
    end

    always_ff @(posedge ClkRs_ix.clk) begin
        if (ClkRs_ix.reset) begin
            state        <= IDLE;
            pending      <= 1'b0;
            scan_hold    <= 1'b0;
            man_idx      <= '0;
            scan_idx     <= '0;
            ack_cnt      <= '0;
            tx_data_ob32 <= '0;
            tx_load_o    <= 1'b0;
            cur_page_ob8 <= '0;
            frames_ob32  <= '0;
            scanning_o   <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            tx_load_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pending || scanning_o) begin
                        state <= SNAP;
                    end
                end
                SNAP: begin
                    tx_data_ob32 <= sel_word;
                    cur_page_ob8 <= snap_idx;
                    pending      <= 1'b0;
                    scan_hold    <= 1'b0;
                    if (tx_busy_i) begin
                        state <= WAIT_IDLE;
                    end else begin
                        state     <= LOAD;
                        tx_load_o <= 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // Nothing is loaded yet, so a newer manual request replaces the snapshot.
                    if (pending) begin
                        state <= SNAP;
                    end else if (!tx_busy_i) begin
                        state     <= LOAD;
                        tx_load_o <= 1'b1;
                    end
                end
                LOAD: begin
                    state   <= WAIT_ACK;
                    ack_cnt <= '0;
                end
                WAIT_ACK: begin
                    if (tx_busy_i) begin
                        state <= WAIT_DONE;
                    end else if (ack_cnt == ACK_LAST) begin
                        timeout_o <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        frames_ob32 <= frames_ob32 + 32'd1;
                        state       <= IDLE;
                        if (scanning_o && !scan_hold) begin
                            scan_idx <= (scan_idx == LAST_IDX) ? 8'd0 : scan_idx + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Requests override anything the FSM did to the selection state this cycle.
            if (req_valid_i) begin
                scanning_o <= req_ib32[31];
                man_idx    <= req_ib32[7:0];
                timeout_o  <= 1'b0;
                pending    <= !req_ib32[31];
                if (req_ib32[31]) begin
                    scan_idx  <= '0;
                    scan_hold <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gbt_page_scheduler.sv
// Directed scenarios plus randomized manual requests against a page-table reference model;
// a TX responder process models busy timing and logs every load.
module tb_gbt_page_scheduler;
    import ckrs_pkg::*;

    localparam int          NP     = 4;
    localparam int          ACK_TO = 16;
    localparam logic [31:0] BAD    = 32'hdeadbeef;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    ckrs_t            ckrs;
    logic [31:0]      req_ib32 = '0;
    logic             req_valid_i = 1'b0;
    logic [31:0]      pg [NP];
    logic [32*NP-1:0] pages_bus;
    logic             tx_busy = 1'b0;
    logic [31:0]      tx_data_ob32;
    logic             tx_load_o;
    logic [7:0]       cur_page_ob8;
    logic [31:0]      frames_ob32;
    logic             scanning_o;
    logic             timeout_o;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;
    int frames_exp = 0;
    int last_ld_cyc = 0;

    int ack_dly = 2;
    int busy_len = 40;
    bit no_ack = 1'b0;
    bit busy_force = 1'b0;
    logic [31:0] ld_dat_q [$];
    logic [7:0]  ld_pg_q [$];
    int          ld_cyc_q [$];

    assign ckrs = '{clk: clk, reset: rst};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        pages_bus = '0;
        for (int k = 0; k < NP; k++) pages_bus[32*k +: 32] = pg[k];
    end

    gbt_page_scheduler #(
        .NUM_PAGES   (NP),
        .ACK_TIMEOUT (ACK_TO),
        .BAD_PAGE    (BAD)
    ) dut (
        .ClkRs_ix     (ckrs),
        .req_ib32     (req_ib32),
        .req_valid_i  (req_valid_i),
        .pages_ib32   (pages_bus),
        .tx_busy_i    (tx_busy),
        .tx_data_ob32 (tx_data_ob32),
        .tx_load_o    (tx_load_o),
        .cur_page_ob8 (cur_page_ob8),
        .frames_ob32  (frames_ob32),
        .scanning_o   (scanning_o),
        .timeout_o    (timeout_o)
    );

    // Serial TX model: busy rises ack_dly cycles after a load and stays high busy_len cycles.
    initial begin
        bit armed;
        bit resp_busy;
        int rise_at;
        int fall_at;
        armed = 1'b0;
        resp_busy = 1'b0;
        rise_at = 0;
        fall_at = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                armed = 1'b0;
                resp_busy = 1'b0;
            end else begin
                if (tx_load_o) begin
                    ld_dat_q.push_back(tx_data_ob32);
                    ld_pg_q.push_back(cur_page_ob8);
                    ld_cyc_q.push_back(cyc);
                    if (!no_ack) begin
                        armed = 1'b1;
                        rise_at = cyc + ack_dly;
                        fall_at = rise_at + busy_len;
                    end
                end
                if (armed && cyc >= fall_at) armed = 1'b0;
                resp_busy = armed && (cyc >= rise_at);
            end
            tx_busy = busy_force | resp_busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] page_word(input int idx);
        if (idx >= 0 && idx < NP) return pg[idx];
        return BAD;
    endfunction

    task automatic send_req(input logic [31:0] r);
        req_ib32 = r;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        req_ib32 = '0;
    endtask

    task automatic wait_load(input int budget, input string tag);
        int n;
        n = 0;
        while (ld_dat_q.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        assert (ld_dat_q.size() != 0) else begin
            n_err++;
            $error("FAIL %s: no load within %0d cycles, observed 0 loads expected 1", tag, budget);
        end
    endtask

    task automatic expect_load(input string tag, input logic [31:0] exp_dat, input logic [7:0] exp_pg);
        logic [31:0] d;
        logic [7:0]  p;
        d = 'x;
        p = 'x;
        wait_load(80, tag);
        if (ld_dat_q.size() != 0) begin
            d = ld_dat_q.pop_front();
            p = ld_pg_q.pop_front();
            last_ld_cyc = ld_cyc_q.pop_front();
        end
        chk({tag, "_dat"}, d, exp_dat);
        chk({tag, "_page"}, {24'd0, p}, {24'd0, exp_pg});
    endtask

    task automatic chk_no_loads(input string tag);
        chk(tag, 32'(ld_dat_q.size()), 32'd0);
    endtask

    task automatic manual_frame(input string tag);
        send_req(32'h0000_0001);
        chk({tag, "_load_t1"}, {31'd0, tx_load_o}, 32'd0);
        tick();
        chk({tag, "_load_t2"}, {31'd0, tx_load_o}, 32'd0);
        tick();
        chk({tag, "_load_t3"}, {31'd0, tx_load_o}, 32'd1);
        chk({tag, "_data_t3"}, tx_data_ob32, 32'h1234_5678);
        expect_load(tag, 32'h1234_5678, 8'd1);
        settle(50);
        frames_exp++;
        chk({tag, "_frames"}, frames_ob32, 32'(frames_exp));
        chk({tag, "_cur_page"}, {24'd0, cur_page_ob8}, 32'd1);
    endtask

    initial begin
        logic [7:0]  idx;
        logic [31:0] exp_w;
        int          wait_n;
        int          L;

        for (int k = 0; k < NP; k++) pg[k] = $urandom;
        pg[1] = 32'h1234_5678;

        // Reset state
        rst = 1'b1;
        settle(3);
        chk("rst_data", tx_data_ob32, 32'd0);
        chk("rst_load", {31'd0, tx_load_o}, 32'd0);
        chk("rst_page", {24'd0, cur_page_ob8}, 32'd0);
        chk("rst_frames", frames_ob32, 32'd0);
        chk("rst_scan", {31'd0, scanning_o}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
        rst = 1'b0;
        settle(2);

        // Single manual frame with latency check
        manual_frame("s1");

        // Out-of-range and boundary page indices
        send_req(32'h0000_00FF);
        expect_load("bad_ff", BAD, 8'hFF);
        settle(50);
        send_req(32'(NP));
        expect_load("bad_np", BAD, 8'(NP));
        settle(50);
        send_req(32'(NP - 1));
        expect_load("last_page", pg[NP-1], 8'(NP - 1));
        settle(50);
        chk_no_loads("s2_extra");
        frames_exp += 3;
        chk("s2_frames", frames_ob32, 32'(frames_exp));

        // Auto-scan with wrap, then drop back to a manual page
        send_req(32'h8000_0000);
        chk("scan_on", {31'd0, scanning_o}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            expect_load($sformatf("scan%0d", i), page_word(i % NP), 8'(i % NP));
        end
        send_req(32'h0000_0002);
        chk("scan_off", {31'd0, scanning_o}, 32'd0);
        expect_load("scan_man", pg[2], 8'd2);
        settle(60);
        chk_no_loads("s3_extra");
        frames_exp += 7;
        chk("s3_frames", frames_ob32, 32'(frames_exp));

        // Ack timeout
        no_ack = 1'b1;
        send_req(32'h0000_0000);
        expect_load("to_load", pg[0], 8'd0);
        L = last_ld_cyc;
        while (cyc < L + ACK_TO - 1) tick();
        chk("to_before", {31'd0, timeout_o}, 32'd0);
        tick();
        chk("to_at", {31'd0, timeout_o}, 32'd1);
        settle(5);
        chk("to_frames", frames_ob32, 32'(frames_exp));
        chk_no_loads("to_no_retry");
        no_ack = 1'b0;
        send_req(32'h0000_0001);
        chk("to_clear", {31'd0, timeout_o}, 32'd0);
        expect_load("to_next", pg[1], 8'd1);
        settle(50);
        frames_exp++;
        chk("to_next_frames", frames_ob32, 32'(frames_exp));

        // Last request wins while TX is held busy
        busy_force = 1'b1;
        settle(2);
        send_req(32'h0000_0003);
        settle(5);
        send_req(32'h0000_0005);
        settle(5);
        send_req(32'h0000_0007);
        settle(10);
        chk_no_loads("held_no_load");
        busy_force = 1'b0;
        expect_load("held", BAD, 8'd7);
        settle(50);
        chk_no_loads("held_extra");
        frames_exp++;
        chk("held_frames", frames_ob32, 32'(frames_exp));

        // Reset during WAIT_DONE
        send_req(32'h0000_0002);
        expect_load("rst_mid_load", pg[2], 8'd2);
        settle(8);
        rst = 1'b1;
        tick();
        chk("rmid_data", tx_data_ob32, 32'd0);
        chk("rmid_load", {31'd0, tx_load_o}, 32'd0);
        chk("rmid_page", {24'd0, cur_page_ob8}, 32'd0);
        chk("rmid_frames", frames_ob32, 32'd0);
        chk("rmid_scan", {31'd0, scanning_o}, 32'd0);
        chk("rmid_timeout", {31'd0, timeout_o}, 32'd0);
        rst = 1'b0;
        frames_exp = 0;
        settle(3);
        chk_no_loads("rmid_no_load");
        manual_frame("s6");

        // Randomized manual requests against the page-table model
        for (int i = 0; i < 20; i++) begin
            ack_dly = $urandom_range(1, 4);
            busy_len = $urandom_range(1, 20);
            for (int k = 0; k < NP; k++) pg[k] = $urandom;
            if ($urandom_range(0, 3) == 0) idx = 8'($urandom_range(NP, 255));
            else idx = 8'($urandom_range(0, NP - 1));
            exp_w = page_word(int'(idx));
            send_req({1'b0, 23'($urandom), idx});
            expect_load($sformatf("rnd%0d", i), exp_w, idx);
            for (int k = 0; k < NP; k++) pg[k] = $urandom;
            wait_n = ack_dly + busy_len + 5;
            settle(wait_n);
            frames_exp++;
            chk($sformatf("rnd%0d_stable", i), tx_data_ob32, exp_w);
            chk($sformatf("rnd%0d_frames", i), frames_ob32, 32'(frames_exp));
        end
        chk_no_loads("rnd_extra");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
